// File: rtl/mux_ctx_nto1.sv
// mux_ctx_nto1: multi-context N-to-1 datapath multiplexer for the CGRA interconnect.
// Per-context selects are loaded through a daisy-chained serial config register, and
// a context counter steps through them while the fabric runs. A select at or beyond
// NUM_INPUTS drives a defined zero output and raises sel_err.
// Build option: define MUX_CTX_OUTPUT_REG_EN to register out/sel_err (1-cycle latency);
// leave it undefined for a purely combinational output path.
module mux_ctx_nto1 #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned NUM_INPUTS = 9,
  parameter int unsigned CONTEXTS   = 4,
  localparam int unsigned SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int unsigned CTX_W     = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1,
  localparam int unsigned CFG_LEN   = CONTEXTS * SEL_W
) (
  input  logic                         CGRA_Clock,
  input  logic                         CGRA_Reset,
  input  logic [NUM_INPUTS*SIZE-1:0]   in,
  output logic [SIZE-1:0]              out,
  output logic                         sel_err,
  input  logic                         ConfigIn,
  output logic                         ConfigOut,
  input  logic                         config_en,
  input  logic                         run,
  output logic [CTX_W-1:0]             ctx
);

  localparam int unsigned SEL_CMP_W = SEL_W + 1;
  localparam logic [SEL_CMP_W-1:0] NUM_INPUTS_CMP = SEL_CMP_W'(NUM_INPUTS);
  localparam logic [CTX_W-1:0]     CTX_LAST       = CTX_W'(CONTEXTS - 1);

  logic [CFG_LEN-1:0] cfg_q, cfg_d;
  logic [CTX_W-1:0]   ctx_q, ctx_d;
  logic [SEL_W-1:0]   cur_sel;
  logic               sel_in_range;
  logic [SIZE-1:0]    mux_data;
  logic [SIZE-1:0]    out_d;
  logic               sel_err_d;

  // Config chain: shift toward bit 0 so the first bit streamed ends up in cfg[0].
  always_comb begin
    cfg_d = cfg_q;
    if (config_en) begin
      cfg_d              = cfg_q >> 1;
      cfg_d[CFG_LEN-1]   = ConfigIn;
    end
  end

  // Context counter: config clears it and has priority over run; run wraps at CONTEXTS-1.
  always_comb begin
    ctx_d = ctx_q;
    if (config_en) begin
      ctx_d = '0;
    end else if (run) begin
      ctx_d = (ctx_q == CTX_LAST) ? '0 : ctx_q + CTX_W'(1);
    end
  end

  // State registers for the config chain and the context counter.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      cfg_q <= '0;
      ctx_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      ctx_q <= ctx_d;
    end
  end

  // Pick the select field belonging to the active context.
  always_comb begin
    cur_sel = '0;
    for (int k = 0; k < int'(CONTEXTS); k++) begin
      if (ctx_q == CTX_W'(k)) begin
        cur_sel = cfg_q[k*SEL_W +: SEL_W];
      end
    end
  end

  // Data mux; an unmatched select leaves zero so out-of-range never yields X.
  always_comb begin
    mux_data     = '0;
    sel_in_range = ({1'b0, cur_sel} < NUM_INPUTS_CMP);
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (cur_sel == SEL_W'(k)) begin
        mux_data = in[k*SIZE +: SIZE];
      end
    end
  end

  // Output value before the optional register: forced quiet while the chain is loading.
  always_comb begin
    out_d     = '0;
    sel_err_d = 1'b0;
    if (!config_en) begin
      if (sel_in_range) begin
        out_d = mux_data;
      end else begin
        sel_err_d = 1'b1;
      end
    end
  end

`ifdef MUX_CTX_OUTPUT_REG_EN
  logic [SIZE-1:0] out_q;
  logic            sel_err_q;

  // Optional output register adding one cycle of data latency.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      out_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out     = out_q;
  assign sel_err = sel_err_q;
`else
  assign out     = out_d;
  assign sel_err = sel_err_d;
`endif

  assign ConfigOut = cfg_q[0];
  assign ctx       = ctx_q;

endmodule

// File: tb/tb_mux_ctx_nto1.sv
// Self-checking bench for mux_ctx_nto1 with default parameters; works for both output builds.
module tb_mux_ctx_nto1;

  localparam int NI  = 9;
  localparam int SZ  = 32;
  localparam int NC  = 4;
  localparam int SW  = 4;
  localparam int CL  = NC * SW;
`ifdef MUX_CTX_OUTPUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst_n;
  logic [NI*SZ-1:0]  in_bus;
  logic [SZ-1:0]     out;
  logic              sel_err;
  logic              cfg_in;
  logic              cfg_out;
  logic              config_en;
  logic              run;
  logic [1:0]        ctx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: config stream as a plain bit array, context as an integer.
  bit          m_cfg [CL];
  int          m_ctx;
  logic [31:0] exp_reg_out;
  logic        exp_reg_err;
  bit          last_stream [CL];

  mux_ctx_nto1 #(.SIZE(SZ), .NUM_INPUTS(NI), .CONTEXTS(NC)) dut (
    .CGRA_Clock (clk),
    .CGRA_Reset (rst_n),
    .in         (in_bus),
    .out        (out),
    .sel_err    (sel_err),
    .ConfigIn   (cfg_in),
    .ConfigOut  (cfg_out),
    .config_en  (config_en),
    .run        (run),
    .ctx        (ctx)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic default_inputs();
    for (int k = 0; k < NI; k++) in_bus[k*SZ +: SZ] = 32'h1000_0000 + 32'(k);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CL; i++) m_cfg[i] = 1'b0;
    m_ctx       = 0;
    exp_reg_out = 32'h0;
    exp_reg_err = 1'b0;
  endtask

  function automatic int model_sel(input int c);
    int s = 0;
    for (int b = 0; b < SW; b++) s += int'(m_cfg[c*SW + b]) << b;
    return s;
  endfunction

  // One cycle: drive at the falling edge, check, advance the model at the rising edge.
  task automatic step(input logic ce, input logic ci, input logic rn);
    logic [31:0] e_out;
    logic        e_err;
    int          s;
    config_en = ce;
    cfg_in    = ci;
    run       = rn;
    #1;
    e_out = 32'h0;
    e_err = 1'b0;
    if (!ce) begin
      s = model_sel(m_ctx);
      if (s < NI) e_out = in_bus[s*SZ +: SZ];
      else        e_err = 1'b1;
    end
    if (REG_OUT) begin
      check("out", out, exp_reg_out);
      check("sel_err", 32'(sel_err), 32'(exp_reg_err));
    end else begin
      check("out", out, e_out);
      check("sel_err", 32'(sel_err), 32'(e_err));
    end
    check("ctx", 32'(ctx), 32'(m_ctx));
    check("config_out", 32'(cfg_out), 32'(m_cfg[0]));
    @(posedge clk);
    exp_reg_out = e_out;
    exp_reg_err = e_err;
    if (ce) begin
      for (int i = 0; i < CL - 1; i++) m_cfg[i] = m_cfg[i+1];
      m_cfg[CL-1] = ci;
      m_ctx = 0;
    end else if (rn) begin
      m_ctx = (m_ctx == NC - 1) ? 0 : m_ctx + 1;
    end
    @(negedge clk);
  endtask

  // Stream four selects, context 0 LSB first.
  task automatic load4(input int s0, input int s1, input int s2, input int s3);
    int v [NC];
    v[0] = s0; v[1] = s1; v[2] = s2; v[3] = s3;
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < SW; b++)
        last_stream[c*SW + b] = bit'((v[c] >> b) & 1);
    for (int i = 0; i < CL; i++) step(1'b1, last_stream[i], 1'b0);
  endtask

  task automatic run_to_ctx(input int target);
    for (int i = 0; i < 2 * NC && m_ctx != target; i++) step(1'b0, 1'b0, 1'b1);
    check("reach_ctx", 32'(m_ctx), 32'(target));
  endtask

  initial begin
    rst_n     = 1'b0;
    config_en = 1'b0;
    cfg_in    = 1'b0;
    run       = 1'b0;
    default_inputs();
    model_reset();

    // Reset with no clock running.
    #3;
    check("rst_ctx", 32'(ctx), 32'h0);
    check("rst_config_out", 32'(cfg_out), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    check("rst_out", out, REG_OUT ? 32'h0 : 32'h1000_0000);

    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_out", out, 32'h1000_0000);

    // Load and run through the wrap.
    load4(8, 3, 0, 5);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);

    // Out-of-range select in context 1.
    load4(8, 12, 0, 5);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1);

    // Daisy chain: original stream reappears on ConfigOut in order.
    for (int i = 0; i < CL; i++) begin
      check("chain_out", 32'(cfg_out), 32'(last_stream[i]));
      step(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);

    // Config asserted mid-run at context 2.
    load4(1, 2, 3, 4);
    run_to_ctx(2);
    step(1'b1, 1'b1, 1'b1);
    check("cfg_run_ctx", 32'(ctx), 32'h0);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NI; k++) in_bus[k*SZ +: SZ] = $urandom;
      step(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset between edges at context 3.
    default_inputs();
    load4(1, 2, 3, 4);
    run_to_ctx(3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_ctx", 32'(ctx), 32'h0);
    check("async_config_out", 32'(cfg_out), 32'h0);
    check("async_sel_err", 32'(sel_err), 32'h0);
    check("async_out", out, REG_OUT ? 32'h0 : 32'h1000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    check("post_async_out", out, 32'h1000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_ctx_nto1.md
# mux_ctx_nto1

Parametrised N-to-1 datapath multiplexer for the CGRA interconnect, and the multi-context successor to the fixed-width 9-to-1 mux. Select values for up to CONTEXTS configuration contexts are loaded through a daisy-chained serial config port. A context counter steps through them cycle by cycle while the fabric runs. Out-of-range selects produce a defined zero output plus an error flag; they never produce X.

## Interface
Parameters:
- SIZE, 32, data width of each input and of the output.
- NUM_INPUTS, 9, number of data inputs (2 or more).
- CONTEXTS, 4, number of stored select contexts (1 or more).
- Derived, not overridable: SEL_W = max(1, clog2(NUM_INPUTS)); CTX_W = max(1, clog2(CONTEXTS)); CFG_LEN = CONTEXTS*SEL_W.

Ports:
- CGRA_Clock  input  1  sole clock; all state updates on the rising edge.
- CGRA_Reset  input  1  asynchronous, active-low reset.
- in  input  NUM_INPUTS*SIZE  flat input bus; input k is in[k*SIZE +: SIZE].
- out  output  SIZE  selected data.
- sel_err  output  1  current select is at least NUM_INPUTS.
- ConfigIn  input  1  serial config bit in.
- ConfigOut  output  1  serial config bit out, to the next block in the chain.
- config_en  input  1  shift-enable for the config chain.
- run  input  1  advance the context counter.
- ctx  output  CTX_W  current context index.

## Operation
- Config chain: a CFG_LEN-bit register cfg.
  - On each edge with config_en=1: cfg <= {ConfigIn, cfg[CFG_LEN-1:1]}.
  - ConfigOut = cfg[0]. It is a register output, so it is glitch-free.
  - Bit order: the first bit shifted lands in cfg[0]. Stream context 0 LSB first, ending with context CONTEXTS-1 MSB.
- Select for context k is cfg[k*SEL_W +: SEL_W].
- Context counter ctx:
  - config_en=1: ctx <= 0. Config has priority over run.
  - config_en=0, run=1: ctx <= (ctx==CONTEXTS-1) ? 0 : ctx+1, so it wraps.
  - config_en=0, run=0: ctx holds.
- Output datapath (pre-register), with sel = select of the current ctx:
  - config_en=1: out value 0, sel_err 0.
  - sel < NUM_INPUTS: out value = input sel, sel_err 0.
  - sel ≥ NUM_INPUTS: out value 0, sel_err 1.
- Reset (CGRA_Reset=0, takes effect immediately):
  - cfg = 0, so every context selects in0.
  - ctx = 0, ConfigOut = 0.
  - Output register, when present: out = 0, sel_err = 0.

## Timing
- Config load takes exactly CFG_LEN edges with config_en=1. Partial loads leave the chain shifted by the number of edges applied. No checking is done.
- When config_en falls, the new selects are visible on the next cycle's datapath, and ctx is 0.
- ctx changes only on clock edges; out tracks ctx, cfg and in according to the latency in Configuration.
- Reset released mid-load or mid-run: the block resumes from the reset state, and the loader must restart the bitstream.
- Simultaneous config_en and run: the chain shifts and ctx clears; run is ignored.

## Configuration
- Macro: MUX_CTX_OUTPUT_REG_EN.
- Defined:
  - out and sel_err are registered on CGRA_Clock, so data latency is 1 cycle: in and ctx at edge t give out after edge t+1.
  - Reset value of out and sel_err is 0.
- Undefined:
  - out and sel_err are purely combinational from in, ctx and cfg, with 0 cycles latency.
  - During reset, out equals in0 and sel_err is 0.
- No other behaviour differs between the two builds.

## Test plan
Defaults throughout (SIZE=32, NUM_INPUTS=9, CONTEXTS=4, SEL_W=4, CFG_LEN=16), with input k = 0x1000_0000+k.
- Reset: assert CGRA_Reset=0 with no clock running.
  - Required: ctx=0, ConfigOut=0, sel_err=0 immediately.
  - out = 0x1000_0000 (combinational build) or 0 (registered build).
  - One edge after release with run=0: out = 0x1000_0000 in both builds.
- Load and run:
  - Shift 16 bits encoding ctx0=8, ctx1=3, ctx2=0, ctx3=5, then hold run=1.
  - Required: out sequence 0x1000_0008, 0x1000_0003, 0x1000_0000, 0x1000_0005, 0x1000_0008, so ctx wraps 3 to 0.
  - The registered build shows the same sequence one cycle later.
- Out-of-range select: load ctx1=12.
  - Required: in ctx1, out=0 and sel_err=1; sel_err=0 in all other contexts.
- Daisy chain: after the load above, shift 16 more bits of 0.
  - Required: ConfigOut emits the original 16-bit stream in its original order.
  - cfg ends as all zeros.
- Config during run: assert config_en at ctx=2 with run=1.
  - Required: ctx=0 after the next edge, out=0 and sel_err=0 while config_en is high.
- Async reset mid-run: pull CGRA_Reset low between edges at ctx=3.
  - Required: ctx=0 and ConfigOut=0 without waiting for a clock edge.
  - After release: out = 0x1000_0000.
